branch_resolve: RTL

//  EX-stage branch resolution unit. Drives unsig_o to the EX comparator and

---
 rtl/branch_resolve.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch resolution, redirect and flush sequencing
//
// Purpose:
//   Resolves B-type, JAL and JALR ops in EX. It picks the comparator signedness,
//   decides taken/not-taken, computes the corrected fetch PC and compares the
//   decision with the IF prediction. On a mispredict it raises a valid/ready
//   redirect to IF. After the handshake it holds flush_o for FLUSH_CYCLES cycles.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   br_*_i / br_ready_o op handshake and operands (pc, imm, rs1, funct3, jal, jalr)
//   pred_taken_i        IF prediction for the op being accepted
//   unsig_o             comparator signedness select (combinational)
//   comp_result_i       comparator result for the op being accepted
//   redirect_*          redirect request to IF (valid/ready, corrected pc)
//   flush_o             squash of younger IF/ID ops
//   link_valid_o/pc_o   pc+4 writeback pulse for JAL/JALR
//   exc_misalign_o      taken target not 4-byte aligned (pulse)
//   exc_illegal_o       reserved B-type funct3 (pulse)
//   taken_cnt_o         saturating count of legal taken ops
//   mispred_cnt_o       saturating count of mispredicts

`ifndef COMP_EQ
`define COMP_EQ 2'b00
`endif
`ifndef COMP_LE
`define COMP_LE 2'b01
`endif
`ifndef COMP_GE
`define COMP_GE 2'b10
`endif
`ifndef UNSIGNED
`define UNSIGNED 1'b1
`endif

module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic [2:0]       br_funct3_i,
  input  logic             br_jal_i,
  input  logic             br_jalr_i,
  input  logic [31:0]      br_pc_i,
  input  logic [31:0]      br_imm_i,
  input  logic [31:0]      br_rs1_i,
  input  logic             pred_taken_i,
  output logic             unsig_o,
  input  logic [1:0]       comp_result_i,
  output logic             redirect_valid_o,
  input  logic             redirect_ready_i,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic             link_valid_o,
  output logic [31:0]      link_pc_o,
  output logic             exc_misalign_o,
  output logic             exc_illegal_o,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int FW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] cnt_q, cnt_d;

  logic        is_jump;
  logic        illegal;
  logic        illegal_f3;
  logic        b_taken;
  logic        taken;
  logic        misalign;
  logic        mispred;
  logic        accept;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] correct_pc;

  assign is_jump = br_jal_i | br_jalr_i;

  // Signedness only matters for BLTU/BGEU; jumps never look at the comparator.
  assign unsig_o = (!is_jump && (br_funct3_i[2:1] == 2'b11)) ? `UNSIGNED : ~`UNSIGNED;

  always_comb begin
    b_taken    = 1'b0;
    illegal_f3 = 1'b0;
    case (br_funct3_i)
      3'b000:         b_taken = (comp_result_i == `COMP_EQ);
      3'b001:         b_taken = (comp_result_i != `COMP_EQ);
      3'b100, 3'b110: b_taken = (comp_result_i == `COMP_LE);
      3'b101, 3'b111: b_taken = (comp_result_i == `COMP_EQ) || (comp_result_i == `COMP_GE);
      default:        illegal_f3 = 1'b1;
    endcase
  end

  // Jumps override funct3, so a jump can never be flagged illegal.
  assign illegal    = !is_jump && illegal_f3;
  assign taken      = is_jump || b_taken;
  assign target     = br_jalr_i ? ((br_rs1_i + br_imm_i) & 32'hFFFF_FFFE)
                                : (br_pc_i + br_imm_i);
  assign pc_plus4   = br_pc_i + 32'd4;
  assign correct_pc = taken ? target : pc_plus4;
  // Without the C extension a taken target must be 4-byte aligned.
  assign misalign   = taken && target[1];
  assign mispred    = !illegal && !misalign && (taken != pred_taken_i);
  assign accept     = br_valid_i && br_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    br_ready_o       = 1'b0;
    redirect_valid_o = 1'b0;
    flush_o          = 1'b0;
    case (state_q)
      IDLE: begin
        br_ready_o = 1'b1;
        if (accept && mispred) state_d = REDIR;
      end
      REDIR: begin
        redirect_valid_o = 1'b1;
        if (redirect_ready_i) begin
          state_d = FLUSH;
          cnt_d   = FW'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        if (cnt_q == FW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_o  <= '0;
      link_valid_o   <= 1'b0;
      link_pc_o      <= '0;
      exc_misalign_o <= 1'b0;
      exc_illegal_o  <= 1'b0;
      taken_cnt_o    <= '0;
      mispred_cnt_o  <= '0;
    end else begin
      link_valid_o   <= 1'b0;
      exc_misalign_o <= 1'b0;
      exc_illegal_o  <= 1'b0;
      if (accept) begin
        // A faulting jump does not retire, so its rd is not written.
        link_valid_o   <= is_jump && !misalign;
        link_pc_o      <= pc_plus4;
        exc_misalign_o <= misalign;
        exc_illegal_o  <= illegal;
        if (mispred) redirect_pc_o <= correct_pc;
        if (taken && !illegal && !misalign && (taken_cnt_o != '1))
          taken_cnt_o <= taken_cnt_o + 1'b1;
        if (mispred && (mispred_cnt_o != '1))
          mispred_cnt_o <= mispred_cnt_o + 1'b1;
      end
    end
  end

endmodule
